// File: rtl/pipe_ctrl_if.sv
// Control-unit bundle: ID-stage fields in, per-stage decoded controls and status out.
// With ILLEGAL_TRAP_EN defined the bundle also carries the sticky illegal_op flag.
interface pipe_ctrl_if #(
   parameter int OPW = 4,
   parameter int FCW = 4,
   parameter int RAW = 4
);
   logic           id_valid;
   logic [OPW-1:0] id_opcode;
   logic [FCW-1:0] id_funct;
   logic [RAW-1:0] id_rs;
   logic [RAW-1:0] id_rt;
   logic [RAW-1:0] id_rd;
   logic           branch_taken;
   logic           overflow;
   logic           resume;

   logic           branch;
   logic           jump;
   logic           halt_seen;
   logic [1:0]     branch_sel;
   logic [1:0]     offset_sel;
   logic [OPW-1:0] alu_op;
   logic [2:0]     alu_src1;
   logic [2:0]     alu_src2;
   logic           mem_read;
   logic           mem_write;
   logic           store_byte;
   logic           reg_write;
   logic           write_op2;
   logic [1:0]     mem_to_reg;
   logic [RAW-1:0] wb_rd;
   logic           stall;
   logic           halted;
   logic           ovf_flag;
`ifdef ILLEGAL_TRAP_EN
   logic           illegal_op;
`endif

   modport master (
      output id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd,
      output branch_taken, overflow, resume,
`ifdef ILLEGAL_TRAP_EN
      input  illegal_op,
`endif
      input  branch, jump, halt_seen, branch_sel, offset_sel,
      input  alu_op, alu_src1, alu_src2, mem_read, mem_write, store_byte,
      input  reg_write, write_op2, mem_to_reg, wb_rd, stall, halted, ovf_flag
   );

   modport slave (
      input  id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd,
      input  branch_taken, overflow, resume,
`ifdef ILLEGAL_TRAP_EN
      output illegal_op,
`endif
      output branch, jump, halt_seen, branch_sel, offset_sel,
      output alu_op, alu_src1, alu_src2, mem_read, mem_write, store_byte,
      output reg_write, write_op2, mem_to_reg, wb_rd, stall, halted, ovf_flag
   );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Registered pipeline control: ID decode, EX/MEM/WB control registers, load-use stall,
// branch flush, overflow squash and halt/drain FSM. Optional ILLEGAL_TRAP_EN traps unknown opcodes.
//
// state   | meaning
// S_RUN   | normal issue from ID
// S_DRAIN | ID treated as bubble, waiting for EX/MEM/WB to empty
// S_HALTED| pipe empty, held until resume
module pipe_ctrl_unit #(
   parameter int OPW = 4,
   parameter int FCW = 4,
   parameter int RAW = 4
) (
   input  logic        clk,
   input  logic        rst,
   pipe_ctrl_if.slave  bus
);
   localparam logic [3:0] OP_NOP = 4'b0000, OP_ATYPE = 4'b0001, OP_LBU = 4'b0100,
                          OP_SB  = 4'b0101, OP_LW    = 4'b0110, OP_SW  = 4'b0111,
                          OP_JMP = 4'b1000, OP_AND   = 4'b1001, OP_OR  = 4'b1010,
                          OP_BLT = 4'b1100, OP_BGT   = 4'b1101, OP_BEQ = 4'b1110,
                          OP_HALT = 4'b1111;

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;
   state_t state, state_nx;

   // Anything outside the opcode map collapses to NOP so it carries zero controls.
   function automatic logic [3:0] norm_op(input logic [OPW-1:0] op);
      if ((op >> 4) != '0) return OP_NOP;
      case (op[3:0])
         OP_ATYPE, OP_LBU, OP_SB, OP_LW, OP_SW, OP_JMP, OP_AND, OP_OR,
         OP_BLT, OP_BGT, OP_BEQ, OP_HALT: return op[3:0];
         default: return OP_NOP;
      endcase
   endfunction

   logic [3:0]     id_op;
   logic           id_illegal, ex_load, load_use, id_accept, halt_cap, ex_ovf;
   logic           ex_v, mem_v, wb_v, mem_kill, wb_kill, ovf_q;
   logic [3:0]     ex_op, mem_op, wb_op;
   logic [FCW-1:0] ex_fn, mem_fn, wb_fn;
   logic [RAW-1:0] ex_rd, mem_rd, wb_rd_q;

   assign id_op = bus.id_valid ? norm_op(bus.id_opcode) : OP_NOP;

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q;
   assign id_illegal = bus.id_valid && (((bus.id_opcode >> 4) != '0) ||
                       (bus.id_opcode[3:0] inside {4'b0010, 4'b0011, 4'b1011}));
   always_ff @(posedge clk) begin
      if (rst) illegal_q <= 1'b0;
      else if (id_illegal && state == S_RUN && !bus.branch_taken) illegal_q <= 1'b1;
   end
   assign bus.illegal_op = illegal_q;
`else
   assign id_illegal = 1'b0;
`endif

   assign ex_load   = ex_v && (ex_op == OP_LW || ex_op == OP_LBU);
   assign load_use  = ex_load && state == S_RUN && !bus.branch_taken &&
                      !(id_op inside {OP_NOP, OP_JMP, OP_HALT}) &&
                      (ex_rd == bus.id_rs || ex_rd == bus.id_rt);
   assign halt_cap  = (id_op == OP_HALT || id_illegal) && state == S_RUN &&
                      !bus.branch_taken && !load_use;
   assign id_accept = bus.id_valid && state == S_RUN && !bus.branch_taken && !load_use &&
                      id_op != OP_HALT && !id_illegal;
   assign ex_ovf    = bus.overflow && ex_v && ex_op == OP_ATYPE;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_v  <= 1'b0;  mem_v  <= 1'b0;  wb_v    <= 1'b0;
         ex_op <= OP_NOP; mem_op <= OP_NOP; wb_op  <= OP_NOP;
         ex_fn <= '0;    mem_fn <= '0;    wb_fn   <= '0;
         ex_rd <= '0;    mem_rd <= '0;    wb_rd_q <= '0;
         mem_kill <= 1'b0; wb_kill <= 1'b0; ovf_q <= 1'b0;
      end else begin
         ex_v  <= id_accept;
         ex_op <= id_op;
         ex_fn <= bus.id_funct;
         ex_rd <= bus.id_rd;
         mem_v <= ex_v;  mem_op <= ex_op;  mem_fn <= ex_fn;  mem_rd <= ex_rd;
         mem_kill <= ex_ovf;
         wb_v  <= mem_v; wb_op  <= mem_op; wb_fn  <= mem_fn; wb_rd_q <= mem_rd;
         wb_kill <= mem_kill;
         if (ex_ovf) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_RUN;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      bus.stall  = load_use;
      bus.halted = 1'b0;
      case (state)
         S_RUN:    if (halt_cap) state_nx = S_DRAIN;
         S_DRAIN: begin
            bus.stall = 1'b1;
            if (!ex_v && !mem_v && !wb_v) state_nx = S_HALTED;
         end
         S_HALTED: begin
            bus.stall  = 1'b1;
            bus.halted = 1'b1;
            if (bus.resume) state_nx = S_RUN;
         end
         default:  state_nx = S_RUN;
      endcase
   end

   always_comb begin
      bus.branch = 1'b0; bus.jump = 1'b0; bus.halt_seen = 1'b0;
      bus.branch_sel = 2'b00; bus.offset_sel = 2'b00;
      case (id_op)
         OP_BLT:  begin bus.branch = 1'b1; bus.offset_sel = 2'b01; bus.branch_sel = 2'b00; end
         OP_BGT:  begin bus.branch = 1'b1; bus.offset_sel = 2'b01; bus.branch_sel = 2'b01; end
         OP_BEQ:  begin bus.branch = 1'b1; bus.offset_sel = 2'b01; bus.branch_sel = 2'b10; end
         OP_JMP:  begin bus.jump = 1'b1; bus.offset_sel = 2'b10; end
         OP_AND, OP_OR: bus.offset_sel = 2'b01;
         OP_HALT: bus.halt_seen = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      bus.alu_op = '0; bus.alu_src1 = 3'b000; bus.alu_src2 = 3'b000;
      if (ex_v) begin
         case (ex_op)
            OP_ATYPE: bus.alu_op = OPW'(ex_op);
            OP_LBU, OP_SB, OP_LW, OP_SW: begin
               bus.alu_op = OPW'(ex_op); bus.alu_src2 = 3'b001;
            end
            OP_AND, OP_OR: begin bus.alu_op = OPW'(ex_op); bus.alu_src1 = 3'b001; end
            OP_BLT, OP_BGT, OP_BEQ: begin bus.alu_op = OPW'(ex_op); bus.alu_src1 = 3'b010; end
            default: ;
         endcase
      end
   end

   assign bus.mem_read   = mem_v && (mem_op == OP_LBU || mem_op == OP_LW);
   assign bus.mem_write  = mem_v && (mem_op == OP_SB || mem_op == OP_SW);
   assign bus.store_byte = mem_v && mem_op == OP_SB;

   // wb_kill carries an overflowed ATYPE down so its register write is suppressed.
   assign bus.reg_write  = wb_v && !wb_kill &&
                           (wb_op inside {OP_ATYPE, OP_AND, OP_OR, OP_LBU, OP_LW});
   assign bus.write_op2  = wb_v && !wb_kill && wb_op == OP_ATYPE && (&wb_fn);
   assign bus.mem_to_reg = !wb_v ? 2'b00 : (wb_op == OP_LW) ? 2'b01 :
                           (wb_op == OP_LBU) ? 2'b10 : 2'b00;
   assign bus.wb_rd      = wb_v ? wb_rd_q : '0;
   assign bus.ovf_flag   = ovf_q;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: directed ID stream, expectations queued per cycle.
module tb_pipe_ctrl_unit;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   typedef struct {
      int          cyc;
      string       name;
      int unsigned val;
   } exp_t;
   exp_t q[$];

   pipe_ctrl_if #(.OPW(4), .FCW(4), .RAW(4)) bus();
   pipe_ctrl_unit #(.OPW(4), .FCW(4), .RAW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int unsigned sig(input string n);
      case (n)
         "branch":     return 32'(bus.branch);
         "jump":       return 32'(bus.jump);
         "halt_seen":  return 32'(bus.halt_seen);
         "branch_sel": return 32'(bus.branch_sel);
         "offset_sel": return 32'(bus.offset_sel);
         "alu_op":     return 32'(bus.alu_op);
         "alu_src1":   return 32'(bus.alu_src1);
         "alu_src2":   return 32'(bus.alu_src2);
         "mem_read":   return 32'(bus.mem_read);
         "mem_write":  return 32'(bus.mem_write);
         "store_byte": return 32'(bus.store_byte);
         "reg_write":  return 32'(bus.reg_write);
         "write_op2":  return 32'(bus.write_op2);
         "mem_to_reg": return 32'(bus.mem_to_reg);
         "wb_rd":      return 32'(bus.wb_rd);
         "stall":      return 32'(bus.stall);
         "halted":     return 32'(bus.halted);
         "ovf_flag":   return 32'(bus.ovf_flag);
         default:      return 32'hDEADBEEF;
      endcase
   endfunction

   always @(negedge clk) begin
      int unsigned got;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].cyc == cyc) begin
            n_tests++;
            got = sig(q[i].name);
            if (got != q[i].val) begin
               n_fail++;
               $display("FAIL %s cyc=%0d got=%0h expected=%0h", q[i].name, cyc, got, q[i].val);
            end
            q.delete(i);
         end else if (q[i].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s cyc=%0d got=unchecked expected=%0h", q[i].name, q[i].cyc, q[i].val);
            q.delete(i);
         end
      end
   end

   task automatic ex(input int off, input string n, input int unsigned v);
      exp_t e;
      e.cyc  = cyc + off;
      e.name = n;
      e.val  = v;
      q.push_back(e);
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] fn,
                        input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd);
      bus.id_valid = v;  bus.id_opcode = op; bus.id_funct = fn;
      bus.id_rs = rs;    bus.id_rt = rt;     bus.id_rd = rd;
      bus.branch_taken = 1'b0; bus.overflow = 1'b0; bus.resume = 1'b0;
   endtask

   task automatic idle();
      drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      ex(0, "stall", 0); ex(0, "halted", 0); ex(0, "ovf_flag", 0); ex(0, "alu_op", 0);
      ex(0, "mem_write", 0); ex(0, "reg_write", 0); ex(0, "wb_rd", 0);
      ex(0, "branch", 0); ex(0, "jump", 0);
      tick();

      // LW r3 then dependent AND: one stall cycle
      drive(1, 4'b0110, 4'h0, 4'd1, 4'd2, 4'd3);
      ex(0, "offset_sel", 0); ex(1, "alu_op", 6); ex(1, "alu_src2", 1);
      ex(2, "mem_read", 1); ex(3, "reg_write", 1); ex(3, "mem_to_reg", 1); ex(3, "wb_rd", 3);
      tick();
      drive(1, 4'b1001, 4'h0, 4'd3, 4'd4, 4'd5);
      ex(0, "stall", 1); ex(0, "offset_sel", 1); ex(1, "alu_op", 0);
      tick();
      drive(1, 4'b1001, 4'h0, 4'd3, 4'd4, 4'd5);
      ex(0, "stall", 0); ex(1, "alu_op", 9); ex(1, "alu_src1", 1); ex(2, "mem_read", 0);
      ex(3, "reg_write", 1); ex(3, "wb_rd", 5); ex(3, "mem_to_reg", 0);
      tick();

      // ATYPE funct all ones without overflow
      drive(1, 4'b0001, 4'hF, 4'd0, 4'd0, 4'd11);
      ex(1, "alu_op", 1); ex(3, "write_op2", 1); ex(3, "reg_write", 1); ex(3, "wb_rd", 11);
      tick();

      // resume in RUN has no effect
      idle(); bus.resume = 1'b1;
      ex(0, "stall", 0); ex(1, "stall", 0); ex(1, "halted", 0);
      tick();

      // BEQ, then JMP and OR both flushed, then ATYPE proceeds
      drive(1, 4'b1110, 4'h0, 4'd1, 4'd2, 4'd0);
      ex(0, "branch", 1); ex(0, "branch_sel", 2); ex(0, "offset_sel", 1);
      ex(1, "alu_op", 14); ex(1, "alu_src1", 2);
      tick();
      drive(1, 4'b1000, 4'h0, 4'd0, 4'd0, 4'd0); bus.branch_taken = 1'b1;
      ex(0, "jump", 1); ex(0, "offset_sel", 2); ex(0, "stall", 0);
      ex(1, "alu_op", 0); ex(1, "alu_src1", 0); ex(3, "reg_write", 0);
      tick();
      drive(1, 4'b1010, 4'h0, 4'd6, 4'd7, 4'd8); bus.branch_taken = 1'b1;
      ex(0, "offset_sel", 1); ex(1, "alu_op", 0); ex(1, "alu_src1", 0);
      ex(3, "reg_write", 0); ex(3, "wb_rd", 0);
      tick();
      drive(1, 4'b0001, 4'h0, 4'd0, 4'd0, 4'd9);
      ex(1, "alu_op", 1); ex(3, "reg_write", 1); ex(3, "wb_rd", 9); ex(3, "write_op2", 0);
      tick();

      // BGT and BLT decode
      drive(1, 4'b1101, 4'h0, 4'd1, 4'd2, 4'd0);
      ex(0, "branch", 1); ex(0, "branch_sel", 1); ex(1, "alu_op", 13);
      tick();
      drive(1, 4'b1100, 4'h0, 4'd1, 4'd2, 4'd0);
      ex(0, "branch", 1); ex(0, "branch_sel", 0); ex(0, "offset_sel", 1);
      ex(1, "alu_op", 12); ex(1, "alu_src1", 2);
      tick();

      // SB, LBU, then an unknown opcode reading LBU's rd (acts as NOP, no stall)
      drive(1, 4'b0101, 4'h0, 4'd0, 4'd0, 4'd0);
      ex(1, "alu_op", 5); ex(1, "alu_src2", 1); ex(2, "mem_write", 1); ex(2, "store_byte", 1);
      ex(3, "reg_write", 0);
      tick();
      drive(1, 4'b0100, 4'h0, 4'd0, 4'd0, 4'd12);
      ex(2, "mem_read", 1); ex(3, "reg_write", 1); ex(3, "mem_to_reg", 2); ex(3, "wb_rd", 12);
      tick();
      drive(1, 4'b0011, 4'h0, 4'd12, 4'd12, 4'd1);
      ex(0, "stall", 0); ex(1, "alu_op", 0);
      tick();

      // overflow squash and sticky flag
      drive(1, 4'b0001, 4'hF, 4'd0, 4'd0, 4'd10);
      ex(0, "stall", 0); ex(3, "reg_write", 0); ex(3, "write_op2", 0);
      tick();
      idle(); bus.overflow = 1'b1;
      ex(0, "ovf_flag", 0); ex(1, "ovf_flag", 1);
      tick();
      idle();
      ex(2, "ovf_flag", 1);
      tick();

      // SW, HALT, drain, halted, resume
      drive(1, 4'b0111, 4'h0, 4'd0, 4'd0, 4'd0);
      ex(1, "alu_op", 7); ex(1, "alu_src2", 1); ex(2, "mem_write", 1); ex(2, "store_byte", 0);
      tick();
      drive(1, 4'b1111, 4'h0, 4'd0, 4'd0, 4'd0);
      ex(0, "halt_seen", 1); ex(0, "stall", 0);
      ex(1, "stall", 1); ex(1, "halted", 0); ex(1, "alu_op", 0);
      ex(2, "alu_op", 0); ex(2, "stall", 1);
      ex(3, "halted", 0); ex(3, "stall", 1); ex(4, "halted", 1); ex(4, "stall", 1);
      ex(5, "halted", 1);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1, 4'b0001, 4'h0, 4'd0, 4'd0, 4'd13);
         tick();
      end
      drive(1, 4'b0001, 4'h0, 4'd0, 4'd0, 4'd13); bus.resume = 1'b1;
      ex(0, "halted", 1); ex(0, "stall", 1); ex(1, "halted", 0); ex(1, "stall", 0);
      ex(2, "alu_op", 1); ex(4, "reg_write", 1); ex(4, "wb_rd", 13);
      tick();
      drive(1, 4'b0001, 4'h0, 4'd0, 4'd0, 4'd13);
      tick();
      idle();
      tick();

      // HALT with simultaneous flush stays in RUN
      drive(1, 4'b1111, 4'h0, 4'd0, 4'd0, 4'd0); bus.branch_taken = 1'b1;
      ex(0, "halt_seen", 1); ex(1, "stall", 0); ex(1, "halted", 0); ex(2, "halted", 0);
      tick();
      idle();
      tick();

      // reset during a load-use stall
      drive(1, 4'b0110, 4'h0, 4'd0, 4'd0, 4'd2);
      tick();
      drive(1, 4'b1010, 4'h0, 4'd2, 4'd0, 4'd1); rst = 1'b1;
      ex(0, "stall", 1);
      tick();
      rst = 1'b0;
      drive(1, 4'b1010, 4'h0, 4'd2, 4'd0, 4'd1);
      ex(0, "stall", 0); ex(0, "ovf_flag", 0); ex(0, "alu_op", 0); ex(0, "mem_read", 0);
      ex(1, "alu_op", 10);
      tick();
      idle();
      repeat (5) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + q.size());
      $finish;
   end
endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Registered successor to the combinational stage decoder of the 5-stage datapath. It carries each instruction's opcode, function code and destination through internal ID/EX/MEM/WB control registers and decodes per-stage control from them. It adds load-use stall detection, branch flush, overflow squash and a halt/drain state machine. It sits beside the datapath pipeline registers and drives the PC-hold and IF/ID-hold signals.

Parameters:
OPW, 4, opcode width (>=4); any opcode with nonzero bits above [3:0] decodes as NOP
FCW, 4, function-code width; WRITE_OP2 is asserted when funct == all ones
RAW, 4, register-address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  instruction present in ID
id_opcode  in  OPW  ID opcode
id_funct  in  FCW  ID function code
id_rs, id_rt, id_rd  in  RAW each  ID source and destination register fields
branch_taken  in  1  branch resolved taken in EX
overflow  in  1  ALU overflow for the EX instruction
resume  in  1  leave HALTED
branch, jump, halt_seen  out  1 each  ID-stage decode
branch_sel, offset_sel  out  2 each  ID-stage decode
alu_op  out  OPW  EX stage
alu_src1, alu_src2  out  3 each  EX stage
mem_read, mem_write, store_byte  out  1 each  MEM stage
reg_write, write_op2  out  1 each  WB stage
mem_to_reg  out  2  WB stage
wb_rd  out  RAW  WB stage
stall  out  1  hold PC and IF/ID
halted  out  1  state is HALTED
ovf_flag  out  1  sticky overflow

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Opcode map: NOP 0000, ATYPE 0001, LBU 0100, SB 0101, LW 0110, SW 0111, JMP 1000, AND 1001, OR 1010, BLT 1100, BGT 1101, BEQ 1110, HALT 1111. Opcodes are unique; there is no aliasing.
- ID outputs (combinational from id_*; all zero when id_valid=0):
  - BLT/BGT/BEQ: branch=1, offset_sel=01, branch_sel=00/01/10 respectively.
  - JMP: jump=1, offset_sel=10.
  - AND/OR: offset_sel=01.
  - HALT: halt_seen=1.
- Stage registers: each of EX, MEM and WB holds {valid, opcode, funct, rd}.
- Stage outputs decode only from valid stage registers; every unlisted output is 0, including alu_op (no latches).
  - EX: alu_op=opcode for ATYPE/AND/OR/LBU/SB/LW/SW/BLT/BGT/BEQ. alu_src1=001 for AND/OR, 010 for branches. alu_src2=001 for loads/stores.
  - MEM: mem_read for LBU/LW. mem_write for SB/SW. store_byte for SB.
  - WB: reg_write for ATYPE/AND/OR/LBU/LW. mem_to_reg = 00 for ALU ops, 01 for LW, 10 for LBU. write_op2 for ATYPE with funct all ones. wb_rd = WB rd.
- Latency: an instruction in ID at cycle t drives EX controls at t+1, MEM at t+2 and WB at t+3.
- Load-use stall:
  - Condition: stall=1 when EX holds a valid LW/LBU, rd_EX == id_rs or rd_EX == id_rt, and the ID op is not NOP/JMP/HALT.
  - Effect: ID is held, a bubble (valid=0) enters EX, and MEM/WB advance.
- Flush: branch_taken=1 loads bubbles into EX (the next cycle) and discards ID. Flush beats stall and beats halt capture.
- Overflow: overflow=1 with a valid ATYPE in EX clears that instruction's reg_write path when it advances to MEM. It sets ovf_flag, which stays set until rst.
- HALT instructions are consumed in ID and never enter EX.
- Halt FSM:
  - RUN: a valid HALT in ID with no flush and no stall moves to DRAIN.
  - DRAIN: stall=1 and ID is treated as a bubble. When EX, MEM and WB are all invalid, move to HALTED.
  - HALTED: stall=1 and halted=1. resume moves to RUN. resume in RUN or DRAIN is ignored.
- Reset: all stage valid bits=0, FSM=RUN, ovf_flag=0, so every output is 0 one cycle after rst. Reset mid-DRAIN or mid-stall aborts immediately.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: a valid ID opcode not in the map (0010, 0011, 1011, or any opcode with nonzero bits above [3:0]) sets sticky output illegal_op, is converted to a bubble, and forces DRAIN exactly as HALT does. illegal_op clears only on rst.
- Undefined: illegal_op does not exist; unknown opcodes pass through the pipe as NOP with zero controls.

Test Plan:
- Reset: rst held 2 cycles, then released with id_valid=0 -> all outputs 0, halted=0, stall=0.
- Sequence: LW rd=3, then AND rs=3 -> stall=1 for exactly one cycle; the AND reaches EX at t+2 with alu_op=1001 and alu_src1=001.
- Flush: BEQ in EX with branch_taken=1 while JMP is in ID -> the JMP never asserts EX/MEM/WB controls; the next ID instruction proceeds normally.
- Overflow: ATYPE funct=1111 with overflow=1 in EX -> no reg_write and no write_op2 at WB; ovf_flag=1 persists.
- Halt: SW, then HALT, then resume after 5 cycles -> SW still asserts mem_write; HALTED is entered 3 cycles after HALT leaves ID (when EX/MEM/WB are empty); stall=1 throughout; resume -> RUN and stall=0 the next cycle.
- Flush vs halt: HALT in ID with simultaneous branch_taken -> FSM stays RUN, halted=0.
